ahb2apb_bridge_param: RTL and testbench

AHB2APB_BRIDGE_PARAM -- requirements
Module: ahb2apb_bridge_param

---
 rtl/ahb_apb_pkg.sv | 36 +++
 rtl/apb_addr_decode.sv | 55 +++++
 rtl/ahb2apb_bridge_param.sv | 213 +++++++++++++++++++++
 tb/tb_ahb2apb_bridge_param.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared encodings, FSM state type and byte-strobe helper for the AHB-to-APB bridge.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        StIdle,
        StCapt,
        StSetup,
        StAccess,
        StErr1,
        StErr2
    } state_e;

    // Byte lanes touched by a transfer of 2**size bytes at addr_lo, for a bus of `lanes` bytes.
    // Callers truncate the 8-bit result to their own strobe width.
    function automatic logic [7:0] size_to_strobe(input logic [2:0] size,
                                                  input logic [2:0] addr_lo,
                                                  input int unsigned lanes);
        logic [2:0]  sz;
        logic [2:0]  off;
        logic [15:0] base;
        sz   = (size > 3'd3) ? 3'd3 : size;
        off  = addr_lo & 3'(lanes - 1);
        base = (16'd1 << (4'd1 << sz)) - 16'd1;
        base = base << off;
        return base[7:0];
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational slave decode: slave index, one-hot select and decode-error flag
// from a captured AHB address and transfer size.
module apb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NSLV    = 4,
    parameter int unsigned SEL_LSB = 12,
    localparam int unsigned IdxW   = (NSLV > 1) ? $clog2(NSLV) : 1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    output logic [IdxW-1:0]   index,
    output logic [NSLV-1:0]   sel,
    output logic              err
);

    // One guard bit above the index field so addresses beyond the slave range are rejected
    // instead of aliasing onto a real slave.
    localparam int unsigned FieldW  = IdxW + 1;
    localparam int unsigned MaxSize = $clog2(DATA_W / 8);

    logic [7:0] amask;
    logic       unused_addr;

    assign unused_addr = ^addr;

    always_comb begin
        index = '0;
        sel   = '0;
        err   = 1'b0;
        amask = (8'd1 << size) - 8'd1;

        if (NSLV > 1) begin
            if (32'(addr[SEL_LSB +: FieldW]) >= NSLV) begin
                err = 1'b1;
            end else begin
                index = addr[SEL_LSB +: IdxW];
            end
        end

        if (size > 3'(MaxSize)) begin
            err = 1'b1;
        end
        if ((addr[2:0] & amask[2:0]) != 3'd0) begin
            err = 1'b1;
        end

        if (!err) begin
            sel[index] = 1'b1;
        end
    end

endmodule

// File: rtl/ahb2apb_bridge_param.sv
// AHB-Lite slave to multi-slave APB bridge: one registered FSM, all bus outputs registered,
// with decode errors, slave errors and an ACCESS wait timeout reported as a two-cycle ERROR.
module ahb2apb_bridge_param
    import ahb_apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NSLV    = 4,
    parameter int unsigned SEL_LSB = 12,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   HSEL,
    input  logic                   HREADYin,
    input  logic                   HWRITE,
    input  logic [ADDR_W-1:0]      HADDR,
    input  logic [DATA_W-1:0]      HWDATA,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HSIZE,
    output logic [DATA_W-1:0]      HRDATA,
    output logic                   HREADYout,
    output logic [1:0]             HRESP,
    output logic [ADDR_W-1:0]      PADDR,
    output logic [DATA_W-1:0]      PWDATA,
    output logic [DATA_W/8-1:0]    PSTRB,
    output logic                   PWRITE,
    output logic                   PENABLE,
    output logic [NSLV-1:0]        PSEL,
    input  logic [NSLV*DATA_W-1:0] PRDATA,
    input  logic [NSLV-1:0]        PREADY,
    input  logic [NSLV-1:0]        PSLVERR
);

    localparam int unsigned StrbW = DATA_W / 8;
    localparam int unsigned IdxW  = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int unsigned CntW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   haddr_q, haddr_d;
    logic                hwrite_q, hwrite_d;
    logic [2:0]          hsize_q, hsize_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   hrdata_q, hrdata_d;
    logic                hready_q, hready_d;
    logic [1:0]          hresp_q, hresp_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [StrbW-1:0]    pstrb_q, pstrb_d;
    logic                penable_q, penable_d;
    logic [NSLV-1:0]     psel_q, psel_d;

    logic [IdxW-1:0]     dec_index;
    logic [NSLV-1:0]     dec_sel;
    logic                dec_err;
    logic                accept;
    logic                pready_sel;
    logic                pslverr_sel;
    logic [DATA_W-1:0]   prdata_sel;
    logic                unused_htrans;

    assign unused_htrans = HTRANS[0];

    apb_addr_decode #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NSLV    (NSLV),
        .SEL_LSB (SEL_LSB)
    ) u_decode (
        .addr  (haddr_q),
        .size  (hsize_q),
        .index (dec_index),
        .sel   (dec_sel),
        .err   (dec_err)
    );

    // HTRANS[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
    assign accept = ((state_q == StIdle) || (state_q == StErr2)) && HSEL && HREADYin
                    && HTRANS[1];

    assign pready_sel  = PREADY[idx_q];
    assign pslverr_sel = PSLVERR[idx_q];
    assign prdata_sel  = PRDATA[idx_q*DATA_W +: DATA_W];

    always_comb begin
        state_d   = state_q;
        haddr_d   = haddr_q;
        hwrite_d  = hwrite_q;
        hsize_d   = hsize_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        hrdata_d  = hrdata_q;
        hready_d  = hready_q;
        hresp_d   = hresp_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        penable_d = penable_q;
        psel_d    = psel_q;

        unique case (state_q)
            StIdle, StErr2: begin
                hresp_d   = HRESP_OKAY;
                psel_d    = '0;
                penable_d = 1'b0;
                if (accept) begin
                    state_d  = StCapt;
                    haddr_d  = HADDR;
                    hwrite_d = HWRITE;
                    hsize_d  = HSIZE;
                    hready_d = 1'b0;
                end else begin
                    state_d  = StIdle;
                    hready_d = 1'b1;
                end
            end
            StCapt: begin
                pwdata_d = HWDATA;
                if (dec_err) begin
                    state_d  = StErr1;
                    hresp_d  = HRESP_ERROR;
                    psel_d   = '0;
                end else begin
                    state_d   = StSetup;
                    psel_d    = dec_sel;
                    idx_d     = dec_index;
                    penable_d = 1'b0;
                    pstrb_d   = hwrite_q ? StrbW'(size_to_strobe(hsize_q, haddr_q[2:0], StrbW))
                                         : '0;
                end
            end
            StSetup: begin
                state_d   = StAccess;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            StAccess: begin
                if (pready_sel) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    if (pslverr_sel) begin
                        state_d = StErr1;
                        hresp_d = HRESP_ERROR;
                    end else begin
                        state_d  = StIdle;
                        hready_d = 1'b1;
                        hresp_d  = HRESP_OKAY;
                        if (!hwrite_q) begin
                            hrdata_d = prdata_sel;
                        end
                    end
                end else if ((TIMEOUT > 0) && (cnt_q == CntW'(TIMEOUT - 1))) begin
                    state_d   = StErr1;
                    hresp_d   = HRESP_ERROR;
                    psel_d    = '0;
                    penable_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StErr1: begin
                state_d  = StErr2;
                hready_d = 1'b1;
                hresp_d  = HRESP_ERROR;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= StIdle;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            hsize_q   <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            hrdata_q  <= '0;
            hready_q  <= 1'b1;
            hresp_q   <= HRESP_OKAY;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            penable_q <= 1'b0;
            psel_q    <= '0;
        end else begin
            state_q   <= state_d;
            haddr_q   <= haddr_d;
            hwrite_q  <= hwrite_d;
            hsize_q   <= hsize_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            hrdata_q  <= hrdata_d;
            hready_q  <= hready_d;
            hresp_q   <= hresp_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            penable_q <= penable_d;
            psel_q    <= psel_d;
        end
    end

    assign HRDATA    = hrdata_q;
    assign HREADYout = hready_q;
    assign HRESP     = hresp_q;
    assign PADDR     = haddr_q;
    assign PWRITE    = hwrite_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PENABLE   = penable_q;
    assign PSEL      = psel_q;

endmodule

// File: tb/tb_ahb2apb_bridge_param.sv
// Directed bench for ahb2apb_bridge_param with default parameters (4 slaves, TIMEOUT 16).
module tb_ahb2apb_bridge_param;

    logic         HCLK = 1'b0;
    logic         HRESET;
    logic         HSEL;
    logic         HREADYin;
    logic         HWRITE;
    logic [31:0]  HADDR;
    logic [31:0]  HWDATA;
    logic [1:0]   HTRANS;
    logic [2:0]   HSIZE;
    logic [31:0]  HRDATA;
    logic         HREADYout;
    logic [1:0]   HRESP;
    logic [31:0]  PADDR;
    logic [31:0]  PWDATA;
    logic [3:0]   PSTRB;
    logic         PWRITE;
    logic         PENABLE;
    logic [3:0]   PSEL;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY;
    logic [3:0]   PSLVERR;

    int checks   = 0;
    int failures = 0;

    ahb2apb_bridge_param #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .NSLV    (4),
        .SEL_LSB (12),
        .TIMEOUT (16)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HREADYin  (HREADYin),
        .HWRITE    (HWRITE),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HRDATA    (HRDATA),
        .HREADYout (HREADYout),
        .HRESP     (HRESP),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PWRITE    (PWRITE),
        .PENABLE   (PENABLE),
        .PSEL      (PSEL),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] s);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = a;
        HWRITE = w;
        HSIZE  = s;
    endtask

    task automatic bus_idle;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
    endtask

    initial begin
        HRESET   = 1'b1;
        HSEL     = 1'b0;
        HREADYin = 1'b1;
        HWRITE   = 1'b0;
        HADDR    = '0;
        HWDATA   = '0;
        HTRANS   = 2'b00;
        HSIZE    = 3'd0;
        PRDATA   = '0;
        PREADY   = 4'hF;
        PSLVERR  = 4'h0;
        tick;
        tick;
        chk("rst_hready", 64'(HREADYout), 64'h1);
        chk("rst_hresp", 64'(HRESP), 64'h0);
        chk("rst_hrdata", 64'(HRDATA), 64'h0);
        chk("rst_psel", 64'(PSEL), 64'h0);
        chk("rst_penable", 64'(PENABLE), 64'h0);
        chk("rst_pstrb", 64'(PSTRB), 64'h0);
        chk("rst_paddr", 64'(PADDR), 64'h0);
        HRESET = 1'b0;

        // Word write to slave 1, zero wait states.
        addr_phase(32'h0000_1004, 1'b1, 3'd2);
        tick;
        chk("wr_capt_hready", 64'(HREADYout), 64'h0);
        bus_idle;
        HWDATA = 32'hA5A5_1234;
        tick;
        chk("wr_setup_psel", 64'(PSEL), 64'h2);
        chk("wr_setup_penable", 64'(PENABLE), 64'h0);
        chk("wr_setup_pstrb", 64'(PSTRB), 64'hF);
        chk("wr_setup_paddr", 64'(PADDR), 64'h1004);
        chk("wr_setup_pwdata", 64'(PWDATA), 64'hA5A5_1234);
        chk("wr_setup_pwrite", 64'(PWRITE), 64'h1);
        tick;
        chk("wr_access_penable", 64'(PENABLE), 64'h1);
        chk("wr_access_psel", 64'(PSEL), 64'h2);
        tick;
        chk("wr_done_hready", 64'(HREADYout), 64'h1);
        chk("wr_done_hresp", 64'(HRESP), 64'h0);
        chk("wr_done_psel", 64'(PSEL), 64'h0);

        // Read from slave 3 with three wait states.
        addr_phase(32'h0000_3000, 1'b0, 3'd2);
        tick;
        bus_idle;
        tick;
        chk("rd_setup_psel", 64'(PSEL), 64'h8);
        chk("rd_setup_pstrb", 64'(PSTRB), 64'h0);
        PREADY = 4'b0111;
        tick;
        tick;
        tick;
        chk("rd_wait_hready", 64'(HREADYout), 64'h0);
        chk("rd_wait_penable", 64'(PENABLE), 64'h1);
        tick;
        PREADY = 4'hF;
        PRDATA[96 +: 32] = 32'hDEAD_BEEF;
        chk("rd_c6_hready", 64'(HREADYout), 64'h0);
        tick;
        chk("rd_hrdata", 64'(HRDATA), 64'hDEAD_BEEF);
        chk("rd_done_hready", 64'(HREADYout), 64'h1);
        chk("rd_done_hresp", 64'(HRESP), 64'h0);

        // Out-of-range slave index.
        addr_phase(32'h0000_5000, 1'b0, 3'd2);
        tick;
        bus_idle;
        tick;
        chk("dec_err1_hready", 64'(HREADYout), 64'h0);
        chk("dec_err1_hresp", 64'(HRESP), 64'h1);
        chk("dec_err1_psel", 64'(PSEL), 64'h0);
        tick;
        chk("dec_err2_hready", 64'(HREADYout), 64'h1);
        chk("dec_err2_hresp", 64'(HRESP), 64'h1);
        tick;
        chk("dec_idle_hresp", 64'(HRESP), 64'h0);

        // Slave 1 never ready: 16 ACCESS cycles then ERROR.
        addr_phase(32'h0000_1000, 1'b0, 3'd2);
        PREADY = 4'b1101;
        tick;
        bus_idle;
        tick;
        repeat (16) tick;
        chk("to_last_access_penable", 64'(PENABLE), 64'h1);
        chk("to_last_access_hresp", 64'(HRESP), 64'h0);
        tick;
        chk("to_err1_psel", 64'(PSEL), 64'h0);
        chk("to_err1_penable", 64'(PENABLE), 64'h0);
        chk("to_err1_hready", 64'(HREADYout), 64'h0);
        chk("to_err1_hresp", 64'(HRESP), 64'h1);
        tick;
        chk("to_err2_hready", 64'(HREADYout), 64'h1);
        chk("to_err2_hresp", 64'(HRESP), 64'h1);
        PREADY = 4'hF;
        tick;

        // Slave error on completion.
        addr_phase(32'h0000_2000, 1'b1, 3'd2);
        tick;
        bus_idle;
        HWDATA  = 32'h0000_5555;
        PSLVERR = 4'b0100;
        tick;
        tick;
        tick;
        chk("slverr_err1_hready", 64'(HREADYout), 64'h0);
        chk("slverr_err1_hresp", 64'(HRESP), 64'h1);
        tick;
        chk("slverr_err2_hready", 64'(HREADYout), 64'h1);
        chk("slverr_err2_hresp", 64'(HRESP), 64'h1);
        PSLVERR = 4'h0;
        tick;

        // Byte write to lane 2, then misaligned word.
        addr_phase(32'h0000_0002, 1'b1, 3'd0);
        tick;
        bus_idle;
        HWDATA = 32'h00AB_0000;
        tick;
        chk("byte_pstrb", 64'(PSTRB), 64'h4);
        chk("byte_psel", 64'(PSEL), 64'h1);
        tick;
        tick;
        chk("byte_done_hready", 64'(HREADYout), 64'h1);
        addr_phase(32'h0000_0002, 1'b1, 3'd2);
        tick;
        bus_idle;
        tick;
        chk("misal_hresp", 64'(HRESP), 64'h1);
        chk("misal_hready", 64'(HREADYout), 64'h0);
        chk("misal_psel", 64'(PSEL), 64'h0);
        tick;
        tick;

        // Reset in the middle of ACCESS.
        addr_phase(32'h0000_1000, 1'b0, 3'd2);
        PREADY = 4'b1101;
        tick;
        bus_idle;
        tick;
        tick;
        chk("mid_access_penable", 64'(PENABLE), 64'h1);
        HRESET = 1'b1;
        tick;
        chk("mrst_hready", 64'(HREADYout), 64'h1);
        chk("mrst_hresp", 64'(HRESP), 64'h0);
        chk("mrst_hrdata", 64'(HRDATA), 64'h0);
        chk("mrst_paddr", 64'(PADDR), 64'h0);
        chk("mrst_pwdata", 64'(PWDATA), 64'h0);
        chk("mrst_pstrb", 64'(PSTRB), 64'h0);
        chk("mrst_pwrite", 64'(PWRITE), 64'h0);
        chk("mrst_penable", 64'(PENABLE), 64'h0);
        chk("mrst_psel", 64'(PSEL), 64'h0);
        HRESET = 1'b0;
        PREADY = 4'hF;

        // Back-to-back write then read to slave 2.
        addr_phase(32'h0000_2008, 1'b1, 3'd2);
        tick;
        bus_idle;
        HWDATA = 32'h1122_3344;
        tick;
        chk("b2b_wr_pwdata", 64'(PWDATA), 64'h1122_3344);
        chk("b2b_wr_psel", 64'(PSEL), 64'h4);
        tick;
        tick;
        chk("b2b_wr_hready", 64'(HREADYout), 64'h1);
        addr_phase(32'h0000_2008, 1'b0, 3'd2);
        PRDATA[64 +: 32] = 32'hCAFE_F00D;
        tick;
        bus_idle;
        tick;
        chk("b2b_rd_pwrite", 64'(PWRITE), 64'h0);
        chk("b2b_rd_psel", 64'(PSEL), 64'h4);
        tick;
        tick;
        chk("b2b_rd_hrdata", 64'(HRDATA), 64'hCAFE_F00D);
        chk("b2b_rd_hready", 64'(HREADYout), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
